spi_master_mc: RTL
==================

Name: spi_master_mc

Overview:
Parametrised successor to the current SPI master. Full-duplex SPI master with:
- all four SPI modes, selected per transfer (CPOL/CPHA)
- a programmable SCLK divider
- NUM_CS one-hot chip selects
- a start/busy/done handshake

It sits between a register/command front end and off-chip SPI slaves, replacing the fixed-mode, single-CS master.

Parameters:
- WIDTH, 8, bits per transfer (>=2), MSB first
- NUM_CS, 4, number of chip-select outputs (>=1)
- DIV_W, 8, width of clk_div input

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  transfer request, sampled each clk
- cs_sel  in  max(1,$clog2(NUM_CS))  target slave index, latched on accept
- cpol  in  1  SCLK idle level, latched on accept
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; latched on accept
- clk_div  in  DIV_W  SCLK half-period = clk_div+1 clk cycles, latched on accept
- tx_data  in  WIDTH  word to send, latched on accept
- miso  in  1  serial data from slave
- mosi  out  1  serial data to slave
- sclk  out  1  SPI clock
- cs_n  out  NUM_CS  active-low chip selects, at most one low
- rx_data  out  WIDTH  last received word, held until next done
- rx_valid  out  1  one-cycle pulse, rx_data updated
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse, transfer complete

Behaviour:
- Reset (async assert, sync release):
  - cs_n all 1; sclk 0; mosi 0; busy 0; done 0; rx_valid 0; rx_data 0; FSM IDLE.
  - Reset mid-transfer aborts immediately. No done pulse.
- Definition: H = latched clk_div+1.
- IDLE:
  - sclk = registered cpol input; mosi 0; busy 0.
  - start=1 is accepted when busy=0 and cs_sel<NUM_CS. Otherwise start is ignored, with no state change.
  - Accept latches cs_sel, cpol, cpha, clk_div, tx_data. The next cycle is SETUP.
- SETUP (H cycles): busy 1; cs_n[sel] 0; sclk = cpol.
  - cpha=0: mosi = tx_data[WIDTH-1] from the first SETUP cycle.
- XFER (2*WIDTH*H cycles): sclk toggles every H cycles, giving 2*WIDTH edges. Edge 1 is leading (away from cpol).
  - cpha=0: miso sampled on each leading edge; mosi shifts to the next bit on each trailing edge except the last.
  - cpha=1: mosi drives the next bit (starting with the MSB) on each leading edge; miso sampled on each trailing edge.
  - Exactly WIDTH samples are taken, shifted in MSB first.
  - The sample uses the miso value in the clk cycle where sclk changes.
- HOLD (H cycles): sclk = cpol; cs_n[sel] still 0; mosi holds the last bit.
- DONE cycle (1 cycle):
  - cs_n all 1; busy 0; done=1; rx_valid=1; rx_data = received word.
  - FSM returns to IDLE.
  - start in this cycle is accepted, giving back-to-back transfers with exactly 1 cycle of CS high.
- Timing: accept at cycle 0 -> busy high for cycles 1..(2*WIDTH+2)*H. done is in the following cycle.
- Inputs are ignored while busy: start, cs_sel, mode, clk_div and tx_data changes have no effect on the current transfer.
- clk_div=0 gives SCLK = clk/2. clk_div all-ones gives a half-period of 2^DIV_W cycles. Counters must not overflow.
- cs_n is never low for more than one index. No glitch on sclk or cs_n: all outputs are registered.

Test Plan:
- Mode 0 loopback, NUM_CS=4, WIDTH=8, clk_div=0, cs_sel=2, tx 0xA5, miso=mosi:
  - only cs_n[2] low for cycles 1..18
  - first sclk rise at cycle 2
  - 8 rising edges
  - done/rx_valid at cycle 19
  - rx_data=0xA5
- Mode 3, clk_div=2, tx 0x3C, slave model drives 0xC3 on falling edges:
  - sclk idles high
  - half-period 3 cycles
  - mosi bits 0,0,1,1,1,1,0,0 observed at rising edges
  - rx_data=0xC3
  - busy for 54 cycles
- Modes 1 and 2, tx 0x81 / 0x7E, slave returns 0x55 / 0xAA: rx_data matches in each mode; sclk idle level matches cpol before and after.
- start pulsed mid-transfer with different tx_data/cs_sel:
  - ignored
  - start held high through done gives a second transfer with 1-cycle cs_n-high gap
  - second transfer uses the newly latched values
- NUM_CS=3, cs_sel=3: start ignored; busy stays 0; cs_n stays 3'b111.
- rst_n asserted at XFER edge 5:
  - cs_n all 1, sclk 0, busy 0 asynchronously
  - no done pulse
  - next transfer after release completes normally with rx_data correct

Source files
------------

// File: rtl/spi_master_mc.sv
// spi_master_mc: full-duplex SPI master with per-transfer CPOL/CPHA,
// programmable SCLK half-period (clk_div+1 cycles) and NUM_CS one-hot
// active-low chip selects. Every output comes straight from a flop.
module spi_master_mc #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CS = 4,
  parameter  int DIV_W  = 8,
  localparam int SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [WIDTH-1:0]  tx_data,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n,
  output logic [WIDTH-1:0]  rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              done
);

  localparam int EDGE_W = $clog2(2 * WIDTH + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * WIDTH);
  localparam logic [EDGE_W-1:0] PRE_LAST  = EDGE_W'(2 * WIDTH - 1);
  localparam logic [SEL_W:0]    NUM_CS_V  = (SEL_W + 1)'(NUM_CS);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

  logic [1:0]        rst_sync_q, rst_sync_d;
  logic              rst_int_n;
  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [WIDTH-1:0]  tx_q, tx_d, rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0]  rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d, done_q, done_d, busy_q, busy_d;
  logic              sclk_q, sclk_d, mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              accept;

  assign accept    = start && ({1'b0, cs_sel} < NUM_CS_V);
  assign rst_int_n = rst_sync_q[1];

  assign mosi     = mosi_q;
  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Reset synchronizer input: shift in ones after release
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  // Reset synchronizer: asserts immediately, releases two clocks later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  // Next-state and registered-output computation for the transfer FSM
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    div_d      = div_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        sclk_d  = cpol;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        cs_n_d  = '1;
        if (accept) begin
          state_d = SETUP;
          cnt_d   = '0;
          busy_d  = 1'b1;
          cpol_d  = cpol;
          cpha_d  = cpha;
          div_d   = clk_div;
          for (int i = 0; i < NUM_CS; i++) cs_n_d[i] = (cs_sel != SEL_W'(i));
          if (!cpha) begin
            mosi_d = tx_data[WIDTH-1];
            tx_d   = tx_data << 1;
          end else begin
            tx_d   = tx_data;
          end
        end
      end
      SETUP: begin
        if (cnt_q == div_q) begin
          state_d = XFER;
          cnt_d   = '0;
          edge_d  = EDGE_W'(1);
          sclk_d  = ~sclk_q;
          if (cpha_q) begin
            mosi_d = tx_q[WIDTH-1];
            tx_d   = tx_q << 1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      XFER: begin
        if ((cnt_q == '0) && (edge_q[0] != cpha_q))
          rx_sh_d = {rx_sh_q[WIDTH-2:0], miso};
        if (cnt_q == div_q) begin
          cnt_d = '0;
          if (edge_q == LAST_EDGE) begin
            state_d = HOLD;
          end else begin
            edge_d = edge_q + EDGE_W'(1);
            sclk_d = ~sclk_q;
            if (cpha_q ? !edge_q[0] : (edge_q[0] && (edge_q != PRE_LAST))) begin
              mosi_d = tx_q[WIDTH-1];
              tx_d   = tx_q << 1;
            end
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == div_q) begin
          state_d    = DONE;
          busy_d     = 1'b0;
          cs_n_d     = '1;
          done_d     = 1'b1;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q;
          sclk_d     = cpol_q;
          mosi_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer in progress
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      div_q      <= '0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      div_q      <= div_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end

endmodule
